// File: rtl/manual_param_sequencer.sv
// manual_param_sequencer: debounced inc/dec/select keys editing N_PARAM saturated parameter registers
module manual_param_sequencer #(
  parameter int N_PARAM = 4,
  parameter int N_BIT = 8,
  parameter int STEP = 1,
  parameter int VMIN = 0,
  parameter int VMAX = 255,
  parameter int RST_VAL = 0,
  parameter int DEB_CYC = 50000,
  parameter int HOLD_CYC = 25000000,
  parameter int REP_CYC = 5000000,
  localparam int SEL_W = N_PARAM > 2 ? $clog2(N_PARAM) : 1
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_inc_btn,
  input  logic                     i_dec_btn,
  input  logic                     i_sel_btn,
  input  logic                     i_lock,
  output logic [SEL_W-1:0]         o_sel,
  output logic [N_BIT-1:0]         o_cur,
  output logic [N_PARAM*N_BIT-1:0] o_values,
  output logic                     o_upd,
  output logic [SEL_W-1:0]         o_upd_idx
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CMAX = HOLD_CYC > REP_CYC ? HOLD_CYC : REP_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [N_BIT:0] LO = (N_BIT+1)'(VMIN);
  localparam logic [N_BIT:0] HI = (N_BIT+1)'(VMAX);
  localparam logic [N_BIT:0] ST = (N_BIT+1)'(STEP);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state, state_n;
  logic [2:0] sync1, sync2, deb, deb_q, prs;
  logic [DW-1:0] dcnt [3];
  logic [CW-1:0] cnt, cnt_n;
  logic dir, dir_n, step, adv, wr, key_up, opp_dn;
  logic [N_BIT-1:0] vals [N_PARAM];
  logic [N_BIT:0] cur_w, up, dn, nv;
  // key bits: 0 = inc, 1 = dec, 2 = sel; all active-low
  always_ff @(posedge i_CLK or negedge i_RST)
    if (!i_RST) begin
      sync1 <= '1;
      sync2 <= '1;
      deb <= '1;
      deb_q <= '1;
      dcnt <= '{default: '0};
    end else begin
      sync1 <= {i_sel_btn, i_dec_btn, i_inc_btn};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++)
        if (sync2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEB_CYC - 1)) begin
          dcnt[i] <= '0;
          deb[i] <= sync2[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  assign prs = deb_q & ~deb;
  assign key_up = dir ? deb[0] : deb[1];
  assign opp_dn = dir ? ~deb[1] : ~deb[0];
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    dir_n = dir;
    step = 1'b0;
    adv = 1'b0;
    if (state == IDLE) begin
      cnt_n = '0;
      if ((prs[0] & deb[1]) | (prs[1] & deb[0])) begin
        state_n = HOLD;
        dir_n = prs[0];
        step = 1'b1;
      end else adv = prs[2] & ~prs[0] & ~prs[1];
    end else if (key_up | opp_dn) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (cnt == (state == HOLD ? CW'(HOLD_CYC - 1) : CW'(REP_CYC - 1))) begin
      state_n = REPEAT;
      cnt_n = '0;
      step = 1'b1;
    end
  end
  // saturating arithmetic one bit wider than the parameter so it never wraps
  assign cur_w = {1'b0, vals[o_sel]};
  assign up = cur_w + ST > HI ? HI : cur_w + ST;
  assign dn = cur_w >= LO + ST ? cur_w - ST : LO;
  assign nv = dir_n ? up : dn;
  assign wr = step & ~i_lock & (nv != cur_w);
  always_ff @(posedge i_CLK or negedge i_RST)
    if (!i_RST) begin
      state <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      o_sel <= '0;
      o_upd <= 1'b0;
      o_upd_idx <= '0;
      vals <= '{default: N_BIT'(RST_VAL)};
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dir <= dir_n;
      o_upd <= wr;
      if (adv) o_sel <= o_sel == SEL_W'(N_PARAM - 1) ? '0 : o_sel + 1'b1;
      if (wr) begin
        vals[o_sel] <= nv[N_BIT-1:0];
        o_upd_idx <= o_sel;
      end
    end
  assign o_cur = vals[o_sel];
  for (genvar k = 0; k < N_PARAM; k++) begin : g_out
    assign o_values[k*N_BIT +: N_BIT] = vals[k];
  end
endmodule
